dvi_timing_gen: RTL and testbench

Video timing generator that sits directly upstream of the TMDS data encoders. It produces horizontal and vertical counters, sync and display-enable, and requests pixels from a frame source with a one-cycle-latency handshake. It emits three 10-bit encoder-input words per pixel clock: blue carries {vsync, hsync, B}, green carries {2'b00, G} and red carries {2'b00, R}. It also emits the shared display-enable that all three encoders consume.

---
 rtl/dvi_timing_gen.sv | 102 ++++++++++
 tb/tb_dvi_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_gen.sv
// Video timing generator feeding three TMDS encoders: raster counters, syncs,
// display enable, line/frame pulses and a one-cycle-latency pixel request.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        pix_req,
    input  logic [23:0] pix_data,
    output logic [9:0]  ch0_out,
    output logic [9:0]  ch1_out,
    output logic [9:0]  ch2_out,
    output logic        ch_de,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active_c;
    logic             hs_c;
    logic             vs_c;
    logic             run_c;

    logic             de_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             line_q;
    logic             frame_q;

    // Raster counters; disabled or reset parks them at the frame origin.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        run_c    = en && !rst;
        active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c     = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_c     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // Request is held off during reset so the source never sees a stray pull.
    assign pix_req = active_c && run_c;

    // Single output register stage keeps de, syncs and pulses mutually aligned.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            de_q    <= active_c;
            hsync_q <= hs_c ? HS_POL : ~HS_POL;
            vsync_q <= vs_c ? VS_POL : ~VS_POL;
            line_q  <= (h_cnt == '0);
            frame_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Source returns data one clock after the request, i.e. alongside de_q.
    assign ch0_out     = {vsync_q, hsync_q, de_q ? pix_data[7:0]   : 8'h00};
    assign ch1_out     = {2'b00,            de_q ? pix_data[15:8]  : 8'h00};
    assign ch2_out     = {2'b00,            de_q ? pix_data[23:16] : 8'h00};
    assign ch_de       = de_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: small, inverted-polarity and default geometries
// checked every cycle against a linear-position raster model.
module tb_dvi_timing_gen;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [N-1:0]        pix_req;
    logic [N-1:0][23:0]  pix_data;
    logic [N-1:0][9:0]   ch0;
    logic [N-1:0][9:0]   ch1;
    logic [N-1:0][9:0]   ch2;
    logic [N-1:0]        ch_de;
    logic [N-1:0]        line_start;
    logic [N-1:0]        frame_start;

    int ha [N] = '{4, 4, 640};
    int hf [N] = '{1, 1, 16};
    int hsw[N] = '{2, 2, 96};
    int hb [N] = '{1, 1, 48};
    int va [N] = '{3, 3, 480};
    int vf [N] = '{1, 1, 10};
    int vsw[N] = '{1, 1, 2};
    int vb [N] = '{1, 1, 33};
    bit hpol[N] = '{1'b0, 1'b1, 1'b0};
    bit vpol[N] = '{1'b0, 1'b1, 1'b0};

    int          t     [N];
    bit          e_de  [N];
    bit          e_hs  [N];
    bit          e_vs  [N];
    bit          e_ls  [N];
    bit          e_fs  [N];
    logic [23:0] e_pix [N];
    bit          req_s [N];
    logic [23:0] pat_s [N];
    bit          started = 1'b0;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    dvi_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0)) u_small (
        .clk(clk), .rst(rst), .en(en), .pix_req(pix_req[0]), .pix_data(pix_data[0]),
        .ch0_out(ch0[0]), .ch1_out(ch1[0]), .ch2_out(ch2[0]), .ch_de(ch_de[0]),
        .line_start(line_start[0]), .frame_start(frame_start[0]));

    dvi_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1)) u_pol (
        .clk(clk), .rst(rst), .en(en), .pix_req(pix_req[1]), .pix_data(pix_data[1]),
        .ch0_out(ch0[1]), .ch1_out(ch1[1]), .ch2_out(ch2[1]), .ch_de(ch_de[1]),
        .line_start(line_start[1]), .frame_start(frame_start[1]));

    dvi_timing_gen u_dflt (
        .clk(clk), .rst(rst), .en(en), .pix_req(pix_req[2]), .pix_data(pix_data[2]),
        .ch0_out(ch0[2]), .ch1_out(ch1[2]), .ch2_out(ch2[2]), .ch_de(ch_de[2]),
        .line_start(line_start[2]), .frame_start(frame_start[2]));

    function automatic logic [23:0] pattern(input int h, input int v);
        return {8'(h) ^ 8'h5a, 8'(v) + 8'h11, 8'(h + 3 * v)};
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s inst%0d @%0t: got %h, expected %h", name, i, $time, act, exp);
        end
    endtask

    // Model: t is the linear raster index of the counter stage in each instance.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int ht, vt, h, v;
            bit run;
            ht  = ha[i] + hf[i] + hsw[i] + hb[i];
            vt  = va[i] + vf[i] + vsw[i] + vb[i];
            h   = t[i] % ht;
            v   = t[i] / ht;
            run = !rst && en;
            e_de[i]  = run && (h < ha[i]) && (v < va[i]);
            e_hs[i]  = (run && h >= ha[i] + hf[i] && h < ha[i] + hf[i] + hsw[i]) ? hpol[i] : !hpol[i];
            e_vs[i]  = (run && v >= va[i] + vf[i] && v < va[i] + vf[i] + vsw[i]) ? vpol[i] : !vpol[i];
            e_ls[i]  = run && (h == 0);
            e_fs[i]  = run && (t[i] == 0);
            e_pix[i] = pattern(h, v);
            t[i]     = run ? (t[i] + 1) % (ht * vt) : 0;
        end
        started = 1'b1;
    end

    // Frame source: answers each request one clock later, junk otherwise.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            pix_data[i] = req_s[i] ? pat_s[i] : 24'($urandom);
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                int ht, h, v;
                bit exp_req;
                logic [7:0] eb, eg, er;
                ht = ha[i] + hf[i] + hsw[i] + hb[i];
                h  = t[i] % ht;
                v  = t[i] / ht;
                exp_req = !rst && en && (h < ha[i]) && (v < va[i]);
                eb = e_de[i] ? e_pix[i][7:0]   : 8'h00;
                eg = e_de[i] ? e_pix[i][15:8]  : 8'h00;
                er = e_de[i] ? e_pix[i][23:16] : 8'h00;
                chk("pix_req",     i, 32'(pix_req[i]),     32'(exp_req));
                chk("ch_de",       i, 32'(ch_de[i]),       32'(e_de[i]));
                chk("line_start",  i, 32'(line_start[i]),  32'(e_ls[i]));
                chk("frame_start", i, 32'(frame_start[i]), 32'(e_fs[i]));
                chk("ch0_out",     i, 32'(ch0[i]), 32'({e_vs[i], e_hs[i], eb}));
                chk("ch1_out",     i, 32'(ch1[i]), 32'({2'b00, eg}));
                chk("ch2_out",     i, 32'(ch2[i]), 32'({2'b00, er}));
                req_s[i] = pix_req[i];
                pat_s[i] = pattern(h, v);
            end
        end
    end

    initial begin
        int de_cnt, vs_cnt, fs1, fs2, j, k, de_d, hs_d;
        bit found;
        logic [7:0] hmask, hmask_p;
        int ls_t[3];

        rst = 1'b1;
        en  = 1'b1;
        pix_data = '0;
        for (int i = 0; i < N; i++) begin
            req_s[i] = 1'b0;
            pat_s[i] = '0;
            t[i]     = 0;
        end

        // Reset held with en high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ch0_small", 0, 32'(ch0[0]), 32'h300);
        chk("rst_ch0_pol",   1, 32'(ch0[1]), 32'h000);
        chk("rst_ch0_dflt",  2, 32'(ch0[2]), 32'h300);
        chk("rst_pix_req",   0, 32'(pix_req), 32'h0);
        chk("rst_de",        0, 32'(ch_de), 32'h0);
        rst = 1'b0;

        // Two small frames: output cycle c reflects raster position c
        de_cnt = 0; vs_cnt = 0; fs1 = -1; fs2 = -1; hmask = '0; hmask_p = '0;
        for (int c = 0; c < 96; c++) begin
            @(posedge clk);
            #1;
            de_cnt += int'(ch_de[0]);
            if (ch0[0][9] == 1'b0) vs_cnt++;
            if (frame_start[0]) begin
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
            if (c < 8) begin
                if (ch0[0][8] == 1'b0) hmask = hmask | 8'(1 << c);
                if (ch0[1][8] == 1'b1) hmask_p = hmask_p | 8'(1 << c);
            end
        end
        chk("de_2frames",   0, 32'(de_cnt), 32'd24);
        chk("vs_2frames",   0, 32'(vs_cnt), 32'd16);
        chk("fs_first",     0, 32'(fs1), 32'd0);
        chk("fs_period",    0, 32'(fs2 - fs1), 32'd48);
        chk("hs_window",    0, 32'(hmask), 32'h60);
        chk("hs_window_pol",1, 32'(hmask_p), 32'h60);

        // Drop en while the small raster sits at h=2, v=1
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (t[0] == 10) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("wait_h2v1", 0, 32'(found), 32'd1);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ch0", 0, 32'(ch0[0]), 32'h300);
        chk("idle_de",  0, 32'(ch_de[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b1;
        j = 0;
        do begin
            @(posedge clk);
            #1;
            j++;
        end while (!frame_start[0] && j < 60);
        chk("fs_after_en", 0, 32'(j), 32'd1);
        de_cnt = 0;
        for (int c = 0; c < 48; c++) begin
            de_cnt += int'(ch_de[0]);
            @(posedge clk);
            #1;
        end
        chk("de_frame_after_en", 0, 32'(de_cnt), 32'd12);
        chk("fs_next_frame",     0, 32'(frame_start[0]), 32'd1);

        // Reset in the middle of line 4
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (t[0] / 8 == 4) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("wait_v4", 0, 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ch0", 0, 32'(ch0[0]), 32'h300);
        chk("midrst_de",  0, 32'(ch_de[0]), 32'd0);
        chk("midrst_req", 0, 32'(pix_req[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_fs",      0, 32'(frame_start[0]), 32'd1);
        chk("restart_fs_dflt", 2, 32'(frame_start[2]), 32'd1);

        // Default geometry: first three lines after the restart
        k = 0; de_d = 0; hs_d = 0;
        ls_t = '{-1, -1, -1};
        for (int c = 0; c < 1700; c++) begin
            if (line_start[2] && k < 3) begin
                ls_t[k] = c;
                k++;
            end
            if (c < 800) begin
                de_d += int'(ch_de[2]);
                if (ch0[2][8] == 1'b0) hs_d++;
            end
            @(posedge clk);
            #1;
        end
        chk("dflt_ls0",     2, 32'(ls_t[0]), 32'd0);
        chk("dflt_line",    2, 32'(ls_t[1] - ls_t[0]), 32'd800);
        chk("dflt_line2",   2, 32'(ls_t[2] - ls_t[1]), 32'd800);
        chk("dflt_de_line", 2, 32'(de_d), 32'd640);
        chk("dflt_hs_line", 2, 32'(hs_d), 32'd96);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
